display_sequencer: RTL and testbench
====================================

# display_sequencer

Controller for the board's six-digit seven-segment display and LED bank. It runs a programmable-rate tick generator and debounces the run/pause and step buttons. A run/pause state machine advances a 4-bit base count up or down, producing six consecutive hex digit values and a blinking LED pattern. The six digit nibbles feed the existing per-digit seven_segment_decoder instances at top level.

## Interface
- CLK_HZ, 50_000_000, input clock frequency; sets the 1 Hz divisor.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised cycles required to accept a button level change (20 ms at 50 MHz).

- in_clk  input  1  system clock, all logic on rising edge.
- in_reset_n  input  1  reset: asynchronous, active-low; one clock; all state cleared while low.
- in_rate  input  2  tick rate select: 0=1 Hz, 1=2 Hz, 2=4 Hz, 3=8 Hz.
- in_dir  input  1  count direction: 0=up, 1=down.
- in_run_btn_n  input  1  raw active-low run/pause button (asynchronous to in_clk).
- in_step_btn_n  input  1  raw active-low single-step button.
- out_digits  output  24  six digit nibbles; out_digits[4k+3:4k] = (base + 5 - k) mod 16, k=0..5 (digit 5 = base).
- out_led  output  10  all ones when blink latch = 1, else all zeros.
- out_running  output  1  1 in RUN state.
- out_tick  output  1  one-cycle pulse in the cycle the base count changes.

## Operation
- Button path, per button: 2-flop synchroniser, then debounce counter. Counter resets whenever the synchronised level equals the debounced level. Debounced level takes the synchronised value once that value has differed for DEBOUNCE_CYCLES consecutive cycles. Press event = debounced level 1→0 transition, one cycle wide. Release produces no event.
- Divisor D = CLK_HZ >> in_rate; divider counts 0..D-1. Terminal cycle: divider == D-1.
- in_rate registered every cycle. When the registered value differs from the previous one, divider clears to 0 and no advance occurs in that cycle.
- FSM states: PAUSE (reset state), RUN.
  - PAUSE: divider held at 0. Run press → RUN. Step press → advance once.
  - RUN: divider counts; at terminal, divider → 0 and advance. Run press → PAUSE, divider → 0. Step press ignored.
  - Run press and step press in the same cycle: run press wins, step dropped.
  - Terminal cycle coinciding with a run press in RUN: advance still occurs, then PAUSE.
- Advance: base ← base+1 (in_dir=0) or base−1 (in_dir=1), modulo 16, so 15→0 up and 0→15 down. Blink latch toggles. out_tick = 1 for that cycle.
- in_dir is sampled at the advance edge only.

## Timing
- Reset values: base 0, out_digits = 24'h012345, blink latch 0, out_led = 10'h000, out_running 0, out_tick 0, divider 0, debounced levels 1 (released), synchronisers 1.
- Reset assertion mid-run: all of the above applied immediately and asynchronously. Removal: first active edge is the first counting cycle.
- Raw press held stable at edge N: debounced level falls at edge N+2+DEBOUNCE_CYCLES, and the press event is high for the following cycle. Step: base, out_digits and out_led update on the next edge, with out_tick high for one cycle after that edge.
- RUN at constant rate: advances exactly every D cycles. First advance occurs D cycles after the edge that entered RUN.
- All outputs registered. out_digits is a combinational add of the registered base and constants only (no decoder inside this block).

## Test plan
- Reset: hold in_reset_n=0 → out_digits=24'h012345, out_led=0, out_running=0, out_tick=0. Release; idle 100 cycles → no change.
- CLK_HZ=80, DEBOUNCE_CYCLES=4, in_rate=3 (D=10). Press run → out_running=1. out_tick pulses every 10 cycles; out_digits steps 012345→123456→234567; out_led alternates 3FF/000.
- Down wrap, PAUSE, in_dir=1, base=0. One step press → base=F, out_digits=24'hF01234, exactly one out_tick. A second press with in_dir=0 → back to 24'h012345.
- Debounce: a 3-cycle low glitch on in_step_btn_n with DEBOUNCE_CYCLES=4 → no advance. A 6-cycle stable press → exactly one advance. Holding the button 1000 cycles → still one advance.
- Rate change mid-count: RUN with in_rate=0 (D=80). Switch to in_rate=3 at divider=50 → no advance that cycle; next out_tick exactly 10 cycles later. Simultaneous run+step press in PAUSE → RUN entered, base unchanged.
- Reset mid-run at base=9 → outputs return to reset values within the same cycle. After release, the FSM is in PAUSE and no ticks occur without a run press.

Source files
------------

// File: rtl/display_sequencer.sv
`timescale 1ns/1ps
// display_sequencer
// Six-digit hex display and LED sequencer: programmable-rate tick divider,
// debounced run/pause and step buttons, and a run/pause state machine that
// steps a 4-bit base count up or down and toggles a blink latch.

// ButtonDebouncer: synchronises one raw active-low button, filters it and
// emits a one-cycle press pulse on each accepted 1->0 level change.
module ButtonDebouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic in_clk,
  input  logic in_reset_n,
  input  logic in_btn_n,
  output logic out_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;

  // The level is accepted only after it has differed for the full count.
  assign w_accept = (r_sync2 != r_level) && (r_count == CNT_LIMIT);

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= in_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter, debounced level and press pulse (falling level only).
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_count <= '0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_press <= w_accept && !r_sync2;
      if (r_sync2 == r_level) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign out_press = r_press;

endmodule

module display_sequencer #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        in_clk,
  input  logic        in_reset_n,
  input  logic [1:0]  in_rate,
  input  logic        in_dir,
  input  logic        in_run_btn_n,
  input  logic        in_step_btn_n,
  output logic [23:0] out_digits,
  output logic [9:0]  out_led,
  output logic        out_running,
  output logic        out_tick
);

  localparam int DIV_W = $clog2(CLK_HZ + 1);
  localparam logic [DIV_W-1:0] CLK_HZ_V = DIV_W'(CLK_HZ);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } seqState_e;

  seqState_e        r_state;
  seqState_e        w_nextState;
  logic [1:0]       r_rate;
  logic [1:0]       r_ratePrev;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_divNext;
  logic [DIV_W-1:0] w_divisor;
  logic             w_terminal;
  logic             w_rateChange;
  logic             w_runPress;
  logic             w_stepPress;
  logic             w_advance;
  logic [3:0]       r_base;
  logic             r_blink;
  logic             r_tick;
  logic [23:0]      w_digits;

  ButtonDebouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_runDebounce (
    .in_clk    (in_clk),
    .in_reset_n(in_reset_n),
    .in_btn_n  (in_run_btn_n),
    .out_press (w_runPress)
  );

  ButtonDebouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_stepDebounce (
    .in_clk    (in_clk),
    .in_reset_n(in_reset_n),
    .in_btn_n  (in_step_btn_n),
    .out_press (w_stepPress)
  );

  // Divisor halves per rate step; terminal is the last count before wrap.
  assign w_divisor    = CLK_HZ_V >> r_rate;
  assign w_terminal   = (r_div == (w_divisor - DIV_W'(1)));
  assign w_rateChange = (r_rate != r_ratePrev);

  // Rate select is registered twice so a change can restart the divider.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_rate     <= 2'd0;
      r_ratePrev <= 2'd0;
    end else begin
      r_rate     <= in_rate;
      r_ratePrev <= r_rate;
    end
  end

  // State register and tick divider.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state <= PAUSE;
      r_div   <= '0;
    end else begin
      r_state <= w_nextState;
      r_div   <= w_divNext;
    end
  end

  // Next state, next divider value and the advance decision.
  always_comb begin
    w_nextState = r_state;
    w_divNext   = '0;
    w_advance   = 1'b0;
    case (r_state)
      PAUSE: begin
        if (w_runPress) begin
          w_nextState = RUN;
        end else if (w_stepPress) begin
          w_advance = 1'b1;
        end
      end
      RUN: begin
        if (w_rateChange) begin
          w_divNext = '0;
        end else if (w_terminal) begin
          w_advance = 1'b1;
        end else begin
          w_divNext = r_div + DIV_W'(1);
        end
        if (w_runPress) begin
          w_nextState = PAUSE;
          w_divNext   = '0;
        end
      end
      default: begin
        w_nextState = PAUSE;
      end
    endcase
  end

  // Base count, blink latch and tick pulse all move on an advance.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_base  <= 4'd0;
      r_blink <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_advance;
      if (w_advance) begin
        r_base  <= in_dir ? (r_base - 4'd1) : (r_base + 4'd1);
        r_blink <= ~r_blink;
      end
    end
  end

  // Digit k shows base + 5 - k, so the top digit is the base itself.
  always_comb begin
    w_digits = '0;
    for (int k = 0; k < 6; k++) begin
      w_digits[4*k +: 4] = r_base + 4'(5 - k);
    end
  end

  assign out_digits  = w_digits;
  assign out_led     = {10{r_blink}};
  assign out_running = (r_state == RUN);
  assign out_tick    = r_tick;

endmodule

// File: tb/tb_display_sequencer.sv
`timescale 1ns/1ps
// tb_display_sequencer
// Self-checking bench for display_sequencer with a small clock and short
// debounce so that every timing relation can be observed cycle by cycle.

module tb_display_sequencer;

  localparam int CLK_HZ          = 80;
  localparam int DEBOUNCE_CYCLES = 4;
  // Edges from driving a raw press (just after edge e0) to the edge where it acts.
  localparam int PRESS_LATENCY   = DEBOUNCE_CYCLES + 4;

  logic        in_clk;
  logic        in_reset_n;
  logic [1:0]  in_rate;
  logic        in_dir;
  logic        in_run_btn_n;
  logic        in_step_btn_n;
  logic [23:0] out_digits;
  logic [9:0]  out_led;
  logic        out_running;
  logic        out_tick;

  int          assertCount;
  int          failCount;
  int          cyc;
  int          tickCount;
  int          runEntry;
  logic [3:0]  expBase;
  bit          expBlink;

  display_sequencer #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .in_clk       (in_clk),
    .in_reset_n   (in_reset_n),
    .in_rate      (in_rate),
    .in_dir       (in_dir),
    .in_run_btn_n (in_run_btn_n),
    .in_step_btn_n(in_step_btn_n),
    .out_digits   (out_digits),
    .out_led      (out_led),
    .out_running  (out_running),
    .out_tick     (out_tick)
  );

  // Free-running clock.
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Edge counter used as the timeline for every expectation.
  always @(posedge in_clk) cyc <= cyc + 1;

  // Tick pulses counted away from the active edge.
  always @(negedge in_clk) if (out_tick === 1'b1) tickCount <= tickCount + 1;

  function automatic logic [23:0] digitsFor(input int b);
    logic [23:0] d;
    for (int k = 0; k < 6; k++) d[4*k +: 4] = 4'((b + 5 - k) % 16);
    return d;
  endfunction

  function automatic logic [9:0] ledFor(input bit blink);
    return blink ? 10'h3FF : 10'h000;
  endfunction

  function automatic int divisorFor(input int rate);
    return CLK_HZ / (1 << rate);
  endfunction

  task automatic doStep();
    @(posedge in_clk);
    #1;
  endtask

  task automatic stepN(input int n);
    repeat (n) doStep();
  endtask

  task automatic applyAdvance(input bit dir);
    expBase  = dir ? 4'((int'(expBase) + 15) % 16) : 4'((int'(expBase) + 1) % 16);
    expBlink = !expBlink;
  endtask

  // Press the step button for holdCycles and wait for any effect to settle.
  task automatic pressStep(input int holdCycles);
    in_step_btn_n = 1'b0;
    stepN(holdCycles);
    in_step_btn_n = 1'b1;
    stepN(PRESS_LATENCY + 8);
  endtask

  task automatic test_reset();
    int t0;
    in_reset_n = 1'b0;
    stepN(3);
    assertCount++;
    if (out_digits !== 24'h012345) begin
      failCount++;
      $display("[TB] FAIL reset_digits: got %h expected %h", out_digits, 24'h012345);
    end
    assertCount++;
    if (out_led !== 10'h000) begin
      failCount++;
      $display("[TB] FAIL reset_led: got %h expected %h", out_led, 10'h000);
    end
    assertCount++;
    if (out_running !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_running: got %b expected 0", out_running);
    end
    assertCount++;
    if (out_tick !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_tick: got %b expected 0", out_tick);
    end
    in_reset_n = 1'b1;
    t0 = tickCount;
    stepN(100);
    assertCount++;
    if (out_digits !== 24'h012345 || out_running !== 1'b0 || (tickCount - t0) != 0) begin
      failCount++;
      $display("[TB] FAIL reset_idle: digits %h running %b ticks %0d, expected 012345 0 0",
               out_digits, out_running, tickCount - t0);
    end
  endtask

  task automatic test_step_wrap();
    int t0;
    bit d;
    // Down step from base 0, with exact press-to-advance latency.
    in_dir = 1'b1;
    t0 = tickCount;
    in_step_btn_n = 1'b0;
    stepN(PRESS_LATENCY - 1);
    assertCount++;
    if (out_tick !== 1'b0 || out_digits !== digitsFor(expBase)) begin
      failCount++;
      $display("[TB] FAIL step_early: tick %b digits %h, expected 0 %h",
               out_tick, out_digits, digitsFor(expBase));
    end
    doStep();
    applyAdvance(1'b1);
    assertCount++;
    if (out_tick !== 1'b1 || out_digits !== digitsFor(expBase) || out_digits !== 24'hF01234) begin
      failCount++;
      $display("[TB] FAIL step_down_wrap: tick %b digits %h, expected 1 F01234", out_tick, out_digits);
    end
    assertCount++;
    if (out_led !== ledFor(expBlink)) begin
      failCount++;
      $display("[TB] FAIL step_led: got %h expected %h", out_led, ledFor(expBlink));
    end
    in_step_btn_n = 1'b1;
    stepN(PRESS_LATENCY + 6);
    assertCount++;
    if ((tickCount - t0) != 1) begin
      failCount++;
      $display("[TB] FAIL step_tick_count: got %0d expected 1", tickCount - t0);
    end
    // Up step back over the wrap.
    in_dir = 1'b0;
    t0 = tickCount;
    pressStep(6);
    applyAdvance(1'b0);
    assertCount++;
    if (out_digits !== 24'h012345 || (tickCount - t0) != 1) begin
      failCount++;
      $display("[TB] FAIL step_up_wrap: digits %h ticks %0d, expected 012345 1", out_digits, tickCount - t0);
    end
    // Random direction steps.
    for (int i = 0; i < 5; i++) begin
      d = 1'($urandom_range(0, 1));
      in_dir = d;
      t0 = tickCount;
      pressStep(6 + int'($urandom_range(0, 4)));
      applyAdvance(d);
      assertCount++;
      if (out_digits !== digitsFor(expBase) || out_led !== ledFor(expBlink) || (tickCount - t0) != 1) begin
        failCount++;
        $display("[TB] FAIL step_random: digits %h led %h ticks %0d, expected %h %h 1",
                 out_digits, out_led, tickCount - t0, digitsFor(expBase), ledFor(expBlink));
      end
    end
  endtask

  task automatic test_debounce();
    int t0;
    int glitch;
    in_dir = 1'($urandom_range(0, 1));
    glitch = int'($urandom_range(1, DEBOUNCE_CYCLES - 1));
    t0 = tickCount;
    pressStep(glitch);
    assertCount++;
    if ((tickCount - t0) != 0 || out_digits !== digitsFor(expBase)) begin
      failCount++;
      $display("[TB] FAIL debounce_glitch: len %0d ticks %0d digits %h, expected 0 %h",
               glitch, tickCount - t0, out_digits, digitsFor(expBase));
    end
    t0 = tickCount;
    pressStep(6);
    applyAdvance(in_dir);
    assertCount++;
    if ((tickCount - t0) != 1 || out_digits !== digitsFor(expBase)) begin
      failCount++;
      $display("[TB] FAIL debounce_press: ticks %0d digits %h, expected 1 %h",
               tickCount - t0, out_digits, digitsFor(expBase));
    end
    t0 = tickCount;
    pressStep(1000);
    applyAdvance(in_dir);
    assertCount++;
    if ((tickCount - t0) != 1 || out_digits !== digitsFor(expBase) || out_led !== ledFor(expBlink)) begin
      failCount++;
      $display("[TB] FAIL debounce_hold: ticks %0d digits %h led %h, expected 1 %h %h",
               tickCount - t0, out_digits, out_led, digitsFor(expBase), ledFor(expBlink));
    end
  endtask

  task automatic test_run_rate3();
    int p, entry, pauseEdge, dv;
    bit dirUsed, expTick, expRun;
    in_rate = 2'd3;
    in_dir  = 1'b0;
    dv      = divisorFor(3);
    stepN(4);
    in_run_btn_n = 1'b0;
    p         = cyc;
    entry     = p + PRESS_LATENCY;
    pauseEdge = entry + 3 * dv + 2 + PRESS_LATENCY;
    while (cyc < entry + 6 * dv) begin
      dirUsed = in_dir;
      doStep();
      expTick = (cyc > entry) && ((cyc - entry) % dv == 0) && (cyc <= pauseEdge);
      expRun  = (cyc >= entry) && (cyc < pauseEdge);
      if (expTick) applyAdvance(dirUsed);
      assertCount++;
      if (out_tick !== expTick) begin
        failCount++;
        $display("[TB] FAIL run_tick: cycle %0d got %b expected %b", cyc - entry, out_tick, expTick);
      end
      assertCount++;
      if (out_running !== expRun) begin
        failCount++;
        $display("[TB] FAIL run_state: cycle %0d got %b expected %b", cyc - entry, out_running, expRun);
      end
      assertCount++;
      if (out_digits !== digitsFor(expBase) || out_led !== ledFor(expBlink)) begin
        failCount++;
        $display("[TB] FAIL run_digits: cycle %0d digits %h led %h, expected %h %h",
                 cyc - entry, out_digits, out_led, digitsFor(expBase), ledFor(expBlink));
      end
      if (cyc == p + 6) in_run_btn_n = 1'b1;
      if (cyc == entry + 3 * dv + 2) in_run_btn_n = 1'b0;
      if (cyc == entry + 3 * dv + 8) in_run_btn_n = 1'b1;
      in_dir = (cyc - entry >= 2 * dv) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic test_rate_change();
    int p, entry, switchAt, clearEdge, pauseEdge, dv;
    bit expTick, expRun;
    in_rate = 2'd0;
    in_dir  = 1'($urandom_range(0, 1));
    dv      = divisorFor(3);
    stepN(4);
    in_run_btn_n = 1'b0;
    p         = cyc;
    entry     = p + PRESS_LATENCY;
    switchAt  = entry + int'($urandom_range(20, 60));
    // The new rate is registered on the next edge and seen as a change one edge later.
    clearEdge = switchAt + 2;
    pauseEdge = clearEdge + 2 * dv + PRESS_LATENCY;
    while (cyc < clearEdge + 5 * dv) begin
      doStep();
      expTick = (cyc > clearEdge) && ((cyc - clearEdge) % dv == 0) && (cyc <= pauseEdge);
      expRun  = (cyc >= entry) && (cyc < pauseEdge);
      if (expTick) applyAdvance(in_dir);
      assertCount++;
      if (out_tick !== expTick || out_running !== expRun) begin
        failCount++;
        $display("[TB] FAIL rate_change: cycle %0d tick %b running %b, expected %b %b",
                 cyc - entry, out_tick, out_running, expTick, expRun);
      end
      assertCount++;
      if (out_digits !== digitsFor(expBase)) begin
        failCount++;
        $display("[TB] FAIL rate_digits: cycle %0d got %h expected %h", cyc - entry, out_digits, digitsFor(expBase));
      end
      if (cyc == p + 6) in_run_btn_n = 1'b1;
      if (cyc == switchAt) in_rate = 2'd3;
      if (cyc == clearEdge + 2 * dv) in_run_btn_n = 1'b0;
      if (cyc == clearEdge + 2 * dv + 6) in_run_btn_n = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    int p;
    bit expRun;
    in_dir = 1'b0;
    stepN(10);
    in_run_btn_n  = 1'b0;
    in_step_btn_n = 1'b0;
    p = cyc;
    runEntry = p + PRESS_LATENCY;
    while (cyc < runEntry + 8) begin
      doStep();
      expRun = (cyc >= runEntry);
      assertCount++;
      if (out_tick !== 1'b0 || out_running !== expRun || out_digits !== digitsFor(expBase)) begin
        failCount++;
        $display("[TB] FAIL run_step_together: cycle %0d tick %b running %b digits %h, expected 0 %b %h",
                 cyc - runEntry, out_tick, out_running, out_digits, expRun, digitsFor(expBase));
      end
      if (cyc == p + 6) begin
        in_run_btn_n  = 1'b1;
        in_step_btn_n = 1'b1;
      end
    end
  endtask

  task automatic test_reset_midrun();
    int guard, t0, dv;
    bit expTick;
    in_dir  = 1'b0;
    dv      = divisorFor(3);
    guard   = 0;
    expTick = 1'b0;
    while (!(expTick && expBase == 4'd9) && guard < 250) begin
      doStep();
      guard++;
      expTick = (cyc > runEntry) && ((cyc - runEntry) % dv == 0);
      if (expTick) applyAdvance(1'b0);
      assertCount++;
      if (out_tick !== expTick || out_digits !== digitsFor(expBase)) begin
        failCount++;
        $display("[TB] FAIL midrun_count: tick %b digits %h, expected %b %h",
                 out_tick, out_digits, expTick, digitsFor(expBase));
      end
    end
    if (guard >= 250) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL midrun_reach9: base %0d not reached within bound", expBase);
    end
    // Assert reset between edges and look before the next edge arrives.
    #2;
    in_reset_n = 1'b0;
    expBase  = 4'd0;
    expBlink = 1'b0;
    #1;
    assertCount++;
    if (out_digits !== 24'h012345 || out_led !== 10'h000 || out_running !== 1'b0 || out_tick !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midrun_reset: digits %h led %h running %b tick %b, expected 012345 000 0 0",
               out_digits, out_led, out_running, out_tick);
    end
    stepN(2);
    #2;
    in_reset_n = 1'b1;
    t0 = tickCount;
    stepN(60);
    assertCount++;
    if (out_running !== 1'b0 || (tickCount - t0) != 0 || out_digits !== digitsFor(expBase)) begin
      failCount++;
      $display("[TB] FAIL midrun_after: running %b ticks %0d digits %h, expected 0 0 %h",
               out_running, tickCount - t0, out_digits, digitsFor(expBase));
    end
  endtask

  // Watchdog so the bench always ends on its own.
  initial begin
    #500000;
    failCount++;
    $display("[TB] FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    assertCount   = 0;
    failCount     = 0;
    cyc           = 0;
    tickCount     = 0;
    runEntry      = 0;
    expBase       = 4'd0;
    expBlink      = 1'b0;
    in_reset_n    = 1'b0;
    in_rate       = 2'd3;
    in_dir        = 1'b0;
    in_run_btn_n  = 1'b1;
    in_step_btn_n = 1'b1;
    test_reset();
    test_step_wrap();
    test_debounce();
    test_run_rate3();
    test_rate_change();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
